// File: rtl/data_selector_pkg.sv
// rtl/data_selector_pkg.sv - shared types, constants and width helpers for data_selector_scan
// Purpose : state encoding, mode constants and parameter-width helpers used by
//           data_selector_scan and its scan_counter.
// Ports   : none (package).
package data_selector_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Channel-index width for an n-channel selector (n >= 2).
   function automatic int sel_width(input int n);
      return $clog2(n);
   endfunction

   // Divider width; one spare bit so SCAN_DIV = 1 still gets a legal vector.
   function automatic int div_width(input int d);
      return $clog2(d) + 1;
   endfunction

endpackage

// File: rtl/data_selector_scan_counter.sv
// rtl/data_selector_scan_counter.sv - channel pointer and dwell divider for auto-scan
// Purpose : holds the scan pointer and the per-channel dwell counter. Exposes
//           the pointer value that will be current after this edge, so the
//           top can register the matching data in the same cycle.
// Ports   : i_clk, i_rst_n       clock, async active-low reset
//           i_load, i_start      load pointer with i_start and clear divider
//           i_run                advance divider (and pointer on wrap)
//           o_ptr_next           pointer in effect after this edge
//           o_step               pointer moves on this edge
module scan_counter
   import data_selector_pkg::*;
#(
   parameter int N        = 4,
   parameter int SCAN_DIV = 4,
   parameter int SW       = sel_width(N),
   parameter int DW       = div_width(SCAN_DIV)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_load,
   input  logic [SW-1:0] i_start,
   input  logic          i_run,
   output logic [SW-1:0] o_ptr_next,
   output logic          o_step
);

   logic [SW-1:0] r_ptr;
   logic [DW-1:0] r_div;
   logic          w_div_last;
   logic [SW-1:0] w_ptr_inc;

   assign w_div_last = (32'(r_div) == SCAN_DIV - 1);
   // Explicit wrap at N-1 so unused codes above N-1 are never produced.
   assign w_ptr_inc  = (32'(r_ptr) == N - 1) ? '0 : r_ptr + 1'b1;
   assign o_step     = i_run & w_div_last;
   assign o_ptr_next = o_step ? w_ptr_inc : r_ptr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
         r_div <= '0;
      end else if (i_load) begin
         r_ptr <= i_start;
         r_div <= '0;
      end else if (i_run) begin
         if (w_div_last) begin
            r_div <= '0;
            r_ptr <= w_ptr_inc;
         end else begin
            r_div <= r_div + 1'b1;
         end
      end else begin
         // Outside scan the pointer is retained; the divider restarts.
         r_div <= '0;
      end
   end

endmodule

// File: rtl/data_selector_scan.sv
// rtl/data_selector_scan.sv - registered N-channel W-bit data selector with auto-scan
// Purpose : selects one of N channels of DIN onto registered Y, either by S
//           (manual) or by cycling channels every SCAN_DIV clocks (scan).
// Ports   : CLK, RST_N   clock, async active-low reset
//           EN           active-low enable; 1 clears outputs
//           MODE         0 manual, 1 auto-scan
//           S            manual select / scan start channel
//           DIN          flattened channels, channel k at DIN[k*W +: W]
//           Y, CH        registered data and its channel index
//           VLD          manual: level; scan: pulse on each new channel
//           ERR          manual select out of range
module data_selector_scan
   import data_selector_pkg::*;
#(
   parameter int W        = 2,
   parameter int N        = 4,
   parameter int SW       = sel_width(N),
   parameter int SCAN_DIV = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            EN,
   input  logic            MODE,
   input  logic [SW-1:0]   S,
   input  logic [N*W-1:0]  DIN,
   output logic [W-1:0]    Y,
   output logic [SW-1:0]   CH,
   output logic            VLD,
   output logic            ERR
);

   state_t        r_state;
   state_t        w_next_state;
   logic [W-1:0]  r_y;
   logic [SW-1:0] r_ch;
   logic          r_vld;
   logic          r_err;

   logic          w_s_legal;
   logic [SW-1:0] w_start;
   logic          w_load;
   logic          w_run;
   logic [SW-1:0] w_ptr_next;
   logic          w_step;
   logic [SW-1:0] w_sel_idx;
   logic [W-1:0]  w_sel_data;

   assign w_s_legal = (32'(S) < N);
   assign w_start   = w_s_legal ? S : '0;

   // EN has priority over MODE in every state.
   always_comb begin
      w_next_state = MANUAL;
      if (EN)
         w_next_state = IDLE;
      else if (MODE == MODE_SCAN)
         w_next_state = SCAN;
   end

   assign w_load = (w_next_state == SCAN) && (r_state != SCAN);
   assign w_run  = (w_next_state == SCAN) && (r_state == SCAN);

   scan_counter #(
      .N        (N),
      .SCAN_DIV (SCAN_DIV),
      .SW       (SW)
   ) u_scan_counter (
      .i_clk      (CLK),
      .i_rst_n    (RST_N),
      .i_load     (w_load),
      .i_start    (w_start),
      .i_run      (w_run),
      .o_ptr_next (w_ptr_next),
      .o_step     (w_step)
   );

   assign w_sel_idx = (w_next_state == SCAN) ? (w_load ? w_start : w_ptr_next) : S;

   // Decoded mux: codes >= N match no channel and yield zero.
   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < N; k++) begin
         if (32'(w_sel_idx) == k)
            w_sel_data = DIN[k*W +: W];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_y     <= '0;
         r_ch    <= '0;
         r_vld   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (w_next_state)
            MANUAL: begin
               if (w_s_legal) begin
                  r_y   <= w_sel_data;
                  r_ch  <= S;
                  r_vld <= 1'b1;
                  r_err <= 1'b0;
               end else begin
                  r_y   <= '0;
                  r_vld <= 1'b0;
                  r_err <= 1'b1;
               end
            end
            SCAN: begin
               r_y   <= w_sel_data;
               r_ch  <= w_sel_idx;
               r_vld <= w_load | w_step;
               r_err <= 1'b0;
            end
            default: begin
               r_y   <= '0;
               r_vld <= 1'b0;
               r_err <= 1'b0;
            end
         endcase
      end
   end

   assign Y   = r_y;
   assign CH  = r_ch;
   assign VLD = r_vld;
   assign ERR = r_err;

endmodule

// File: tb/tb_data_selector_scan.sv
// tb/tb_data_selector_scan.sv - self-checking bench for data_selector_scan
module tb_data_selector_scan;

   localparam int W   = 2;
   localparam int N   = 4;
   localparam int SW  = 2;
   localparam int D   = 3;
   localparam int N3  = 3;
   localparam int SW3 = 2;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic EN = 1'b1;
   logic MODE = 1'b0;
   logic [SW-1:0]   S = '0;
   logic [N*W-1:0]  DIN = '0;
   logic [SW3-1:0]  S3 = '0;
   logic [N3*W-1:0] DIN3 = '0;
   logic [W-1:0]    Y, Y3;
   logic [SW-1:0]   CH;
   logic [SW3-1:0]  CH3;
   logic VLD, ERR, VLD3, ERR3;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   data_selector_scan #(.W(W), .N(N), .SW(SW), .SCAN_DIV(D)) dut (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .S(S), .DIN(DIN),
      .Y(Y), .CH(CH), .VLD(VLD), .ERR(ERR)
   );

   data_selector_scan #(.W(W), .N(N3), .SW(SW3), .SCAN_DIV(1)) dut3 (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .S(S3), .DIN(DIN3),
      .Y(Y3), .CH(CH3), .VLD(VLD3), .ERR(ERR3)
   );

   // Reference model: scan position derived from elapsed cycles since entry.
   logic [W-1:0]  m_y;
   logic [SW-1:0] m_ch;
   logic          m_vld, m_err, m_scanning;
   int            m_start, m_t;

   function automatic logic [W-1:0] din_of(input logic [N*W-1:0] d, input int k);
      logic [N*W-1:0] t;
      t = d >> (k * W);
      return t[W-1:0];
   endfunction

   function automatic int start_of(input logic [SW-1:0] s);
      return (int'(s) < N) ? int'(s) : 0;
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_y <= '0; m_ch <= '0; m_vld <= 1'b0; m_err <= 1'b0;
         m_scanning <= 1'b0; m_start <= 0; m_t <= 0;
      end else if (EN) begin
         m_y <= '0; m_vld <= 1'b0; m_err <= 1'b0; m_scanning <= 1'b0;
      end else if (MODE == 1'b0) begin
         m_scanning <= 1'b0;
         if (int'(S) < N) begin
            m_y <= din_of(DIN, int'(S)); m_ch <= S; m_vld <= 1'b1; m_err <= 1'b0;
         end else begin
            m_y <= '0; m_vld <= 1'b0; m_err <= 1'b1;
         end
      end else if (!m_scanning) begin
         m_scanning <= 1'b1;
         m_start <= start_of(S);
         m_t <= 0;
         m_ch <= SW'(start_of(S));
         m_y <= din_of(DIN, start_of(S));
         m_vld <= 1'b1; m_err <= 1'b0;
      end else begin
         m_t <= m_t + 1;
         m_ch <= SW'((m_start + (m_t + 1) / D) % N);
         m_y <= din_of(DIN, (m_start + (m_t + 1) / D) % N);
         m_vld <= ((m_t + 1) % D == 0);
         m_err <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [W-1:0] y, input logic [SW-1:0] ch,
                       input logic vld, input logic err);
      chk({tag, ".y"}, 32'(Y), 32'(y));
      chk({tag, ".ch"}, 32'(CH), 32'(ch));
      chk({tag, ".vld"}, 32'(VLD), 32'(vld));
      chk({tag, ".err"}, 32'(ERR), 32'(err));
   endtask

   task automatic chk3(input string tag, input logic [W-1:0] y, input logic [SW3-1:0] ch,
                       input logic vld, input logic err);
      chk({tag, ".y3"}, 32'(Y3), 32'(y));
      chk({tag, ".ch3"}, 32'(CH3), 32'(ch));
      chk({tag, ".vld3"}, 32'(VLD3), 32'(vld));
      chk({tag, ".err3"}, 32'(ERR3), 32'(err));
   endtask

   task automatic cyc(input logic en, input logic md, input logic [SW-1:0] s,
                      input logic [N*W-1:0] din);
      @(negedge CLK);
      EN = en; MODE = md; S = s; DIN = din;
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic en; logic md; logic [1:0] s; logic [7:0] din;
      logic [1:0] y; logic [1:0] ch; logic vld; logic err;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic en, input logic md, input logic [1:0] s, input logic [7:0] din,
                      input logic [1:0] y, input logic [1:0] ch, input logic vld, input logic err);
      vec_t v;
      v.en = en; v.md = md; v.s = s; v.din = din;
      v.y = y; v.ch = ch; v.vld = vld; v.err = err;
      tbl.push_back(v);
   endtask

   initial begin
      logic [1:0] sy [13];
      logic [1:0] sc [13];
      logic       sv [13];
      logic       md;

      // Manual, disable, DIN tracking
      add(0, 0, 2, 8'he4, 2'b10, 2, 1, 0);
      add(0, 0, 3, 8'he4, 2'b11, 3, 1, 0);
      add(1, 0, 3, 8'he4, 2'b00, 3, 0, 0);
      add(0, 0, 3, 8'he4, 2'b11, 3, 1, 0);
      add(0, 0, 0, 8'h1b, 2'b11, 0, 1, 0);
      add(1, 0, 0, 8'he4, 2'b00, 0, 0, 0);
      // Scan from ch1, three cycles per channel, with wrap
      sy = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01};
      sc = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
      sv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 13; i++) add(0, 1, 1, 8'he4, sy[i], sc[i], sv[i], 0);
      // Scan -> manual, EN beats MODE change, re-entry, S ignored mid-scan
      add(0, 0, 2, 8'he4, 2'b10, 2, 1, 0);
      add(1, 1, 3, 8'he4, 2'b00, 2, 0, 0);
      add(0, 1, 3, 8'he4, 2'b11, 3, 1, 0);
      add(0, 1, 0, 8'he4, 2'b11, 3, 0, 0);
      add(0, 0, 1, 8'he4, 2'b01, 1, 1, 0);

      repeat (2) @(posedge CLK);
      #1;
      chk4("reset", 2'b00, 0, 0, 0);
      RST_N = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].en, tbl[i].md, tbl[i].s, tbl[i].din);
         chk4($sformatf("tbl%0d", i), tbl[i].y, tbl[i].ch, tbl[i].vld, tbl[i].err);
      end

      // Asynchronous reset mid-cycle clears outputs without an edge
      #2 RST_N = 1'b0;
      #1 chk4("async_rst", 2'b00, 0, 0, 0);
      RST_N = 1'b1;

      // Reset mid-scan, restart from S=0 with a fresh divider
      cyc(0, 1, 1, 8'he4);
      chk4("ms_entry", 2'b01, 1, 1, 0);
      cyc(0, 1, 1, 8'he4);
      cyc(0, 1, 1, 8'he4);
      cyc(0, 1, 1, 8'he4);
      chk4("ms_ch2", 2'b10, 2, 1, 0);
      cyc(0, 1, 1, 8'he4);
      chk4("ms_ch2b", 2'b10, 2, 0, 0);
      #2 S = 0; RST_N = 1'b0;
      #1 chk4("ms_rst", 2'b00, 0, 0, 0);
      @(posedge CLK);
      @(posedge CLK);
      #2 RST_N = 1'b1;
      cyc(0, 1, 0, 8'he4);
      chk4("ms_re0", 2'b00, 0, 1, 0);
      cyc(0, 1, 0, 8'he4);
      chk4("ms_re1", 2'b00, 0, 0, 0);
      cyc(0, 1, 0, 8'he4);
      chk4("ms_re2", 2'b00, 0, 0, 0);
      cyc(0, 1, 0, 8'he4);
      chk4("ms_re3", 2'b01, 1, 1, 0);

      // N=3 instance: out-of-range select, then SCAN_DIV=1 scanning
      DIN3 = 6'b10_01_11;
      S3 = 2'd1;
      cyc(0, 0, 0, 8'he4);
      chk3("n3_s1", 2'b01, 1, 1, 0);
      S3 = 2'd3;
      cyc(0, 0, 0, 8'he4);
      chk3("n3_s3", 2'b00, 1, 0, 1);
      S3 = 2'd0;
      cyc(0, 0, 0, 8'he4);
      chk3("n3_s0", 2'b11, 0, 1, 0);
      S3 = 2'd3;
      cyc(0, 1, 0, 8'he4);
      chk3("n3_sc0", 2'b11, 0, 1, 0);
      cyc(0, 1, 0, 8'he4);
      chk3("n3_sc1", 2'b01, 1, 1, 0);
      cyc(0, 1, 0, 8'he4);
      chk3("n3_sc2", 2'b10, 2, 1, 0);
      cyc(0, 1, 0, 8'he4);
      chk3("n3_sc3", 2'b11, 0, 1, 0);

      // Randomized run against the reference model
      md = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) md = ~md;
         cyc(($urandom_range(0, 9) == 0), md, SW'($urandom), 8'($urandom));
         chk4($sformatf("rnd%0d", i), m_y, m_ch, m_vld, m_err);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
